data_req_gen: RTL and testbench
===============================

// Module: data_req_gen
// PURPOSE
//  Parametrised read-address generator for the input feature-map block RAM. Walks a conv sliding window
//  (any kernel size, stride, channel count) and issues one read per cycle, stallable by the consumer.
//  Sits between the layer controller (start/abort) and the data BRAM port; replaces fixed 3-line requester.
// PARAMETERS
//  ADDR_WIDTH         32  width of BRAM word address
//  REG_WIDTH          32  width of config registers
//  DIM_WIDTH           8  width of W/H/C fields
//  KERNEL_SIZE_WIDTH   4  width of kernel-size and stride fields
// PORTS
//  clk                 in   1           clock
//  rst                 in   1           synchronous, active-high reset
//  i_start             in   1           pulse: latch config, begin walk (ignored unless idle)
//  i_abort             in   1           drop current walk, return idle, no o_done
//  i_stall             in   1           consumer back-pressure; no read issued while high
//  i_base_addr         in   ADDR_WIDTH  address of channel 0, row 0, x 0
//  i_conf_inputshape   in   REG_WIDTH   [7:0] W, [15:8] H, [23:16] C (fields DIM_WIDTH wide)
//  i_conf_kernelshape  in   REG_WIDTH   [3:0] K (square kernel), [7:4] stride S
//  o_addr              out  ADDR_WIDTH  read address, valid when o_rden
//  o_rden              out  1           read enable
//  o_line_end          out  1           high with o_rden on last word (x=W-1) of each line
//  o_busy              out  1           walk in progress (SETUP or RUN)
//  o_done              out  1           one-cycle pulse after final read
//  o_cfg_err           out  1           one-cycle pulse (with o_done) on illegal config
// BEHAVIOUR
//  Reset: FSM IDLE; o_addr=0; o_rden, o_line_end, o_busy, o_done, o_cfg_err = 0; all counters 0.
//  FSM: IDLE -i_start-> SETUP -> RUN -last read-> DONE -> IDLE. Config latched on i_start in IDLE.
//  SETUP (1 cycle): illegal if W,H,C,K or S ==0 or K>H -> go DONE with o_cfg_err, zero reads issued.
//   else register plane=H*W (2*DIM_WIDTH bits) and row_step=S*W; o_addr <= i_base_addr.
//  Latency: i_start at cycle t -> first o_rden at t+2 if i_stall low.
//  o_rden = (state==RUN) & ~i_stall (combinational); every counter/address update gated by o_rden.
//  Walk order (outer->inner): out-row r (row_start=r*S), kernel row k 0..K-1, channel c 0..C-1, x 0..W-1.
//  o_addr = base + c*plane + (row_start+k)*W + x, built incrementally (adders only, no runtime multiply):
//   x wrap -> line base += plane; c wrap -> krow base += W, line base = krow base;
//   k wrap -> row base += row_step, krow base = line base = row base.
//  Out-rows continue while row_start+S+K <= H (no division); last read = last x/c/k of final out-row.
//  DONE: o_done=1 one cycle, o_busy=0; back to IDLE next cycle. i_start in DONE ignored.
//  i_abort (any non-IDLE state) -> IDLE next edge, o_rden low that cycle onward, no o_done; beats i_stall.
//  i_start while busy: ignored. i_start with i_abort in IDLE: abort wins (stay IDLE).
//  rst mid-walk: immediate reset values next edge, no o_done.
//  Address arithmetic modulo 2^ADDR_WIDTH (wraps silently); dims zero-extended before adds.
//  i_stall in final cycle: final read and o_done delayed until stall drops.
// STRUCTURE
//  Shared header dnn_acc_defs.vh: config field offsets/widths (W,H,C,K,S), FSM state encodings.
//  One sub-module: wrap_cnt (enable, max, count, wrap flag) instantiated for x, c, k counters.
//  Row/krow/line base registers and FSM stay in data_req_gen.
// TESTING
//  W=4,H=4,C=1,K=3,S=1,base=0, no stall -> addr 0-3,4-7,8-11,4-7,8-11,12-15; 24 reads; o_done at read24+1.
//  W=4,H=4,C=2,K=3,S=1 -> first lines 0-3,16-19,4-7,20-23,8-11,24-27 then row 1; 48 reads.
//  W=4,H=5,C=1,K=3,S=2,base=100 -> rows start 100 and 108; 24 reads; o_line_end on every 4th read.
//  Random i_stall (50%) on case 1 -> same address sequence, no read lost/duplicated while stalled.
//  K=5,H=4 (and separately S=0) -> o_cfg_err+o_done pulse at t+2, zero o_rden.
//  i_abort after 10 reads, rst after 10 reads in separate runs -> o_rden low next cycle, no o_done; restart OK.

Source files
------------

// File: rtl/data_req_gen_pkg.sv
// Shared definitions for the sliding-window read-address generator:
// config register field positions and FSM state encoding.
package data_req_gen_pkg;

  // Field index within the shape registers. Each field is DIM_WIDTH
  // (input shape) or KERNEL_SIZE_WIDTH (kernel shape) bits wide.
  localparam int W_FIELD = 0;
  localparam int H_FIELD = 1;
  localparam int C_FIELD = 2;
  localparam int K_FIELD = 0;
  localparam int S_FIELD = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/data_req_gen_if.sv
// Read-request bus between the address generator and the data BRAM port,
// including the consumer back-pressure signal.
interface data_req_gen_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] addr;
  logic                  rden;
  logic                  line_end;
  logic                  stall;

  modport master (output addr, rden, line_end, input stall);
  modport slave  (input addr, rden, line_end, output stall);

endinterface

// File: rtl/data_req_gen_wrap_cnt.sv
// Enabled up-counter that returns to zero after reaching max; used for the
// x, channel and kernel-row loops of the window walk.
module data_req_gen_wrap_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             last,
  output logic             wrap
);

  assign last = (count == max);
  assign wrap = en & last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of always_ff ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/data_req_gen.sv
// Sliding-window read-address generator: walks out-rows, kernel rows,
// channels and x positions, issuing one BRAM read per unstalled cycle.
module data_req_gen
  import data_req_gen_pkg::*;
#(
  parameter int ADDR_WIDTH        = 32,
  parameter int REG_WIDTH         = 32,
  parameter int DIM_WIDTH         = 8,
  parameter int KERNEL_SIZE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [REG_WIDTH-1:0]  i_conf_inputshape,
  input  logic [REG_WIDTH-1:0]  i_conf_kernelshape,
  data_req_gen_if.master        rd,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_cfg_err
);

  localparam int DW = DIM_WIDTH;
  localparam int KW = KERNEL_SIZE_WIDTH;
  localparam int RW = DIM_WIDTH + 2;  // row arithmetic: H + S + K fits

  state_t              state;
  logic [DW-1:0]       cfg_w, cfg_h, cfg_c;
  logic [KW-1:0]       cfg_k, cfg_s;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [2*DW-1:0]     plane;
  logic [DW+KW-1:0]    row_step;
  logic [ADDR_WIDTH-1:0] row_base, krow_base, line_base, addr_q;
  logic [RW-1:0]       row_start;

  logic          rden;
  logic [DW-1:0] x_cnt, c_cnt;
  logic [KW-1:0] k_cnt;
  logic          x_last, x_wrap, c_last, c_wrap, k_last, k_wrap;
  logic          more_rows, last_read, cfg_bad;

  // NOTE: rden is combinational so a stall or abort suppresses the read in
  // the same cycle; all walk state below advances only on rden.
  assign rden = (state == ST_RUN) & ~rd.stall & ~i_abort;

  assign rd.rden     = rden;
  assign rd.addr     = addr_q;
  assign rd.line_end = rden & x_last;

  data_req_gen_wrap_cnt #(.WIDTH(DW)) u_x_cnt (
    .clk(clk), .rst(rst), .clr(state != ST_RUN), .en(rden),
    .max(cfg_w - DW'(1)), .count(x_cnt), .last(x_last), .wrap(x_wrap)
  );

  data_req_gen_wrap_cnt #(.WIDTH(DW)) u_c_cnt (
    .clk(clk), .rst(rst), .clr(state != ST_RUN), .en(x_wrap),
    .max(cfg_c - DW'(1)), .count(c_cnt), .last(c_last), .wrap(c_wrap)
  );

  data_req_gen_wrap_cnt #(.WIDTH(KW)) u_k_cnt (
    .clk(clk), .rst(rst), .clr(state != ST_RUN), .en(c_wrap),
    .max(cfg_k - KW'(1)), .count(k_cnt), .last(k_last), .wrap(k_wrap)
  );

  // Another out-row fits if the next window start plus K stays inside H.
  assign more_rows = (row_start + RW'(cfg_s) + RW'(cfg_k)) <= RW'(cfg_h);
  assign last_read = k_wrap & ~more_rows;

  assign cfg_bad = (cfg_w == '0) || (cfg_h == '0) || (cfg_c == '0) ||
                   (cfg_k == '0) || (cfg_s == '0) || (RW'(cfg_k) > RW'(cfg_h));

  logic lint_unused;
  assign lint_unused = ^{x_cnt, c_cnt, k_cnt, c_last, k_last,
                         i_conf_inputshape[REG_WIDTH-1:3*DW],
                         i_conf_kernelshape[REG_WIDTH-1:2*KW]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_cfg_err <= 1'b0;
      cfg_w     <= '0;
      cfg_h     <= '0;
      cfg_c     <= '0;
      cfg_k     <= '0;
      cfg_s     <= '0;
      base_q    <= '0;
      plane     <= '0;
      row_step  <= '0;
      row_base  <= '0;
      krow_base <= '0;
      line_base <= '0;
      addr_q    <= '0;
      row_start <= '0;
    end else begin
      o_done    <= 1'b0;
      o_cfg_err <= 1'b0;
      if (i_abort && state != ST_IDLE) begin
        state  <= ST_IDLE;
        o_busy <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (i_start && !i_abort) begin
              cfg_w  <= i_conf_inputshape[W_FIELD*DW +: DW];
              cfg_h  <= i_conf_inputshape[H_FIELD*DW +: DW];
              cfg_c  <= i_conf_inputshape[C_FIELD*DW +: DW];
              cfg_k  <= i_conf_kernelshape[K_FIELD*KW +: KW];
              cfg_s  <= i_conf_kernelshape[S_FIELD*KW +: KW];
              base_q <= i_base_addr;
              o_busy <= 1'b1;
              state  <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (cfg_bad) begin
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
              o_cfg_err <= 1'b1;
              state     <= ST_DONE;
            end else begin
              plane     <= (2*DW)'(cfg_h) * (2*DW)'(cfg_w);
              row_step  <= (DW+KW)'(cfg_s) * (DW+KW)'(cfg_w);
              row_base  <= base_q;
              krow_base <= base_q;
              line_base <= base_q;
              addr_q    <= base_q;
              row_start <= '0;
              state     <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (last_read) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else if (k_wrap) begin
              row_base  <= row_base + ADDR_WIDTH'(row_step);
              krow_base <= row_base + ADDR_WIDTH'(row_step);
              line_base <= row_base + ADDR_WIDTH'(row_step);
              addr_q    <= row_base + ADDR_WIDTH'(row_step);
              row_start <= row_start + RW'(cfg_s);
            end else if (c_wrap) begin
              krow_base <= krow_base + ADDR_WIDTH'(cfg_w);
              line_base <= krow_base + ADDR_WIDTH'(cfg_w);
              addr_q    <= krow_base + ADDR_WIDTH'(cfg_w);
            end else if (x_wrap) begin
              line_base <= line_base + ADDR_WIDTH'(plane);
              addr_q    <= line_base + ADDR_WIDTH'(plane);
            end else if (rden) begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_req_gen.sv
// Scoreboard bench for data_req_gen: expected reads are queued from a
// closed-form window model and checked by a monitor on every o_rden.
module tb_data_req_gen;

  typedef struct packed {
    logic [31:0] addr;
    logic        line_end;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] base_addr;
  logic [31:0] conf_in;
  logic [31:0] conf_k;
  logic        busy, done, cfg_err;

  data_req_gen_if #(.ADDR_WIDTH(32)) rif ();

  data_req_gen #(
    .ADDR_WIDTH(32), .REG_WIDTH(32), .DIM_WIDTH(8), .KERNEL_SIZE_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(start),
    .i_abort(abort),
    .i_base_addr(base_addr),
    .i_conf_inputshape(conf_in),
    .i_conf_kernelshape(conf_k),
    .rd(rif.master),
    .o_busy(busy),
    .o_done(done),
    .o_cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt, done_cnt, first_rd_cyc, last_rd_cyc, done_cyc, start_cyc;
  logic done_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every read pops one expected entry from the scoreboard.
  always @(negedge clk) begin
    if (rif.rden) begin
      exp_t e;
      check("read_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rd_addr", 64'(rif.addr), 64'(e.addr));
        check("rd_line_end", 64'(rif.line_end), 64'(e.line_end));
      end
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      rd_cnt++;
    end else if (rif.line_end) begin
      check("line_end_without_rden", 64'(rif.line_end), 64'd0);
    end
    if (cfg_err) check("cfg_err_with_done", 64'(done), 64'd1);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = cfg_err;
    end
  end

  task automatic clear_stats();
    rd_cnt = 0; done_cnt = 0; first_rd_cyc = -1; last_rd_cyc = -1;
    done_cyc = -1; done_err = 1'b0;
  endtask

  // Reference: addr = base + c*H*W + (r*S + k)*W + x.
  task automatic push_model(input int w, h, c, k, s, input int base);
    for (int r = 0; r * s + k <= h; r++)
      for (int kk = 0; kk < k; kk++)
        for (int cc = 0; cc < c; cc++)
          for (int xx = 0; xx < w; xx++)
            sb.push_back('{addr: 32'(base + cc * h * w + (r * s + kk) * w + xx),
                           line_end: (xx == w - 1)});
  endtask

  task automatic start_walk(input int w, h, c, k, s, input int base);
    @(posedge clk); #1;
    conf_in   = {8'd0, 8'(c), 8'(h), 8'(w)};
    conf_k    = {24'd0, 4'(s), 4'(k)};
    base_addr = 32'(base);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic run_walk(input string name, input int w, h, c, k, s, base,
                          input bit stall_mode, input bit mid_start, input int exp_n);
    clear_stats();
    push_model(w, h, c, k, s, base);
    start_walk(w, h, c, k, s, base);
    for (int n = 0; n < 4000 && done_cnt == 0; n++) begin
      @(posedge clk); #1;
      if (stall_mode) rif.stall = 1'($urandom_range(0, 1));
      start = mid_start && (n == 5);
    end
    rif.stall = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check({name, "_done_count"}, 64'(done_cnt), 64'd1);
    check({name, "_reads"}, 64'(rd_cnt), 64'(exp_n));
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({name, "_done_after_last"}, 64'(done_cyc), 64'(last_rd_cyc + 1));
    check({name, "_no_cfg_err"}, 64'(done_err), 64'd0);
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    if (!stall_mode) check({name, "_first_latency"}, 64'(first_rd_cyc), 64'(start_cyc + 2));
    sb.delete();
  endtask

  task automatic cfg_err_run(input string name, input int w, h, c, k, s);
    clear_stats();
    start_walk(w, h, c, k, s, 0);
    for (int n = 0; n < 20 && done_cnt == 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_done_count"}, 64'(done_cnt), 64'd1);
    check({name, "_done_cycle"}, 64'(done_cyc), 64'(start_cyc + 2));
    check({name, "_cfg_err"}, 64'(done_err), 64'd1);
    check({name, "_reads"}, 64'(rd_cnt), 64'd0);
  endtask

  // Interrupt a case-1 walk after 10 reads with abort (use_rst=0) or rst.
  task automatic interrupt_run(input string name, input bit use_rst, input int exp_reads);
    clear_stats();
    push_model(4, 4, 1, 3, 1, 0);
    start_walk(4, 4, 1, 3, 1, 0);
    for (int n = 0; n < 200 && rd_cnt < 10; n++) begin
      @(posedge clk); #1;
    end
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check({name, "_rden_low"}, 64'(rif.rden), 64'd0);
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    if (use_rst) check({name, "_addr_reset"}, 64'(rif.addr), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check({name, "_reads"}, 64'(rd_cnt), 64'(exp_reads));
    check({name, "_no_done"}, 64'(done_cnt), 64'd0);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rif.stall = 1'b0;
    base_addr = '0; conf_in = '0; conf_k = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_addr", 64'(rif.addr), 64'd0);
    check("reset_rden", 64'(rif.rden), 64'd0);
    check("reset_line_end", 64'(rif.line_end), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_cfg_err", 64'(cfg_err), 64'd0);

    run_walk("case1", 4, 4, 1, 3, 1, 0, 1'b0, 1'b0, 24);
    run_walk("case2", 4, 4, 2, 3, 1, 0, 1'b0, 1'b1, 48);
    run_walk("case3", 4, 5, 1, 3, 2, 100, 1'b0, 1'b0, 24);
    run_walk("case1_stall", 4, 4, 1, 3, 1, 0, 1'b1, 1'b0, 24);

    cfg_err_run("k_gt_h", 4, 4, 1, 5, 1);
    cfg_err_run("s_zero", 4, 4, 1, 3, 0);

    interrupt_run("abort", 1'b0, 10);
    run_walk("after_abort", 4, 4, 1, 3, 1, 0, 1'b0, 1'b0, 24);
    // rst is not a combinational read gate: the read in the rst cycle still issues.
    interrupt_run("reset", 1'b1, 11);
    run_walk("after_reset", 4, 5, 1, 3, 2, 100, 1'b0, 1'b0, 24);

    // start together with abort while idle: abort wins.
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", 64'(busy), 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("start_abort_reads", 64'(rd_cnt), 64'd0);
    check("start_abort_done", 64'(done_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
